// File: rtl/ser2par_pkg.sv
// Shared constants and helpers for the serial-to-parallel converter.
// Holds the bit-order selectors and the bit-counter width calculation.
package ser2par_pkg;

  localparam int LSB_FIRST = 0;
  localparam int MSB_FIRST = 1;

  // A counter of at least one bit is kept even for the smallest word.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/ser2par_param.sv
// Serial-to-parallel converter: gathers WIDTH qualified serial bits into a word
// and presents it on a registered valid/ready output with overflow and framing flags.
module ser2par_param
  import ser2par_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          din,
  input  logic                          valid_in,
  input  logic                          sof_in,
  output logic [WIDTH-1:0]              dout,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [cnt_width(WIDTH)-1:0]   bit_cnt,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int            CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST      = CW'(WIDTH - 1);
  localparam bit            MSB_ORDER = (MSB_FIRST == ser2par_pkg::MSB_FIRST);

  logic [WIDTH-1:0] asm_r;
  logic [CW-1:0]    bit_cnt_r;
  logic [WIDTH-1:0] dout_r;
  logic             valid_r;
  logic             overflow_r;
  logic             frame_err_r;

  logic [CW-1:0]    cnt_eff_s;
  logic [WIDTH-1:0] base_s;
  logic [CW-1:0]    pos_s;
  logic [WIDTH-1:0] word_s;
  logic             complete_s;
  logic [WIDTH-1:0] asm_next_s;
  logic [CW-1:0]    cnt_next_s;
  logic             frame_err_next_s;
  logic [WIDTH-1:0] dout_next_s;
  logic             valid_next_s;
  logic             overflow_next_s;

  // Assembly path: a start-of-frame restarts the word at bit 0 with a clean register.
  always_comb begin
    cnt_eff_s        = bit_cnt_r;
    base_s           = asm_r;
    asm_next_s       = asm_r;
    cnt_next_s       = bit_cnt_r;
    frame_err_next_s = 1'b0;
    if (sof_in) begin
      cnt_eff_s = '0;
      base_s    = '0;
    end else begin
      cnt_eff_s = bit_cnt_r;
      base_s    = asm_r;
    end
    if (MSB_ORDER) begin
      pos_s = LAST - cnt_eff_s;
    end else begin
      pos_s = cnt_eff_s;
    end
    word_s        = base_s;
    word_s[pos_s] = din;
    complete_s    = valid_in && (cnt_eff_s == LAST);
    if (valid_in) begin
      asm_next_s       = word_s;
      frame_err_next_s = sof_in && (bit_cnt_r != '0);
      if (complete_s) begin
        cnt_next_s = '0;
      end else begin
        cnt_next_s = cnt_eff_s + CW'(1);
      end
    end else begin
      asm_next_s = asm_r;
      cnt_next_s = bit_cnt_r;
    end
  end

  // Output register: a completed word loads when the slot is empty or draining this cycle.
  always_comb begin
    dout_next_s     = dout_r;
    valid_next_s    = valid_r;
    overflow_next_s = 1'b0;
    if (complete_s && (!valid_r || ready_out)) begin
      dout_next_s  = word_s;
      valid_next_s = 1'b1;
    end else if (complete_s) begin
      overflow_next_s = 1'b1;
    end else if (valid_r && ready_out) begin
      valid_next_s = 1'b0;
    end else begin
      valid_next_s = valid_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_r       <= '0;
      bit_cnt_r   <= '0;
      dout_r      <= '0;
      valid_r     <= 1'b0;
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      asm_r       <= asm_next_s;
      bit_cnt_r   <= cnt_next_s;
      dout_r      <= dout_next_s;
      valid_r     <= valid_next_s;
      overflow_r  <= overflow_next_s;
      frame_err_r <= frame_err_next_s;
    end
  end

  assign dout      = dout_r;
  assign valid_out = valid_r;
  assign bit_cnt   = bit_cnt_r;
  assign overflow  = overflow_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ser2par_param.sv
// Directed bench for ser2par_param: LSB-first and MSB-first instances share stimulus;
// a vector table covers basic assembly and overflow, hand sequences cover framing, gaps and reset.
module tb_ser2par_param;

  typedef struct {
    logic       din;
    logic       vin;
    logic       sof;
    logic       rdy;
    logic       rst;
    logic [7:0] el;
    logic [7:0] em;
    logic       ev;
    logic [2:0] ec;
    logic       eo;
    logic       ef;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       din;
  logic       valid_in;
  logic       sof_in;
  logic       ready_out;
  logic [7:0] dout_l, dout_m;
  logic       valid_l, valid_m;
  logic [2:0] cnt_l, cnt_m;
  logic       ovf_l, ovf_m;
  logic       fe_l, fe_m;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  ser2par_param #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .valid_in(valid_in), .sof_in(sof_in),
    .dout(dout_l), .valid_out(valid_l), .ready_out(ready_out),
    .bit_cnt(cnt_l), .overflow(ovf_l), .frame_err(fe_l)
  );

  ser2par_param #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .valid_in(valid_in), .sof_in(sof_in),
    .dout(dout_m), .valid_out(valid_m), .ready_out(ready_out),
    .bit_cnt(cnt_m), .overflow(ovf_m), .frame_err(fe_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic d, v, s, r, rs, input logic [7:0] el, em,
                     input logic ev, input logic [2:0] ec, input logic eo, ef);
    vec_t x;
    x.din = d; x.vin = v; x.sof = s; x.rdy = r; x.rst = rs;
    x.el = el; x.em = em; x.ev = ev; x.ec = ec; x.eo = eo; x.ef = ef;
    tbl.push_back(x);
  endtask

  task automatic drive(input logic d, v, s, r, rs);
    din = d; valid_in = v; sof_in = s; ready_out = r; rst = rs;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] el, em, input logic ev,
                     input logic [2:0] ec, input logic eo, ef);
    n_vec++;
    if (dout_l !== el) begin
      n_bad++;
      $display("FAIL %s dout_lsb got=%h exp=%h", nm, dout_l, el);
    end
    if (dout_m !== em) begin
      n_bad++;
      $display("FAIL %s dout_msb got=%h exp=%h", nm, dout_m, em);
    end
    if ({valid_l, cnt_l, ovf_l, fe_l} !== {ev, ec, eo, ef}) begin
      n_bad++;
      $display("FAIL %s lsb {valid,cnt,ovf,ferr} got=%b,%0d,%b,%b exp=%b,%0d,%b,%b",
               nm, valid_l, cnt_l, ovf_l, fe_l, ev, ec, eo, ef);
    end
    if ({valid_m, cnt_m, ovf_m, fe_m} !== {ev, ec, eo, ef}) begin
      n_bad++;
      $display("FAIL %s msb {valid,cnt,ovf,ferr} got=%b,%0d,%b,%b exp=%b,%0d,%b,%b",
               nm, valid_m, cnt_m, ovf_m, fe_m, ev, ec, eo, ef);
    end
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] wl [3];
    logic [7:0] wm [3];
    logic [7:0] cur_l, cur_m;
    logic       cur_v;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    s = 8'h4D;

    // Reset, then 4D on consecutive cycles with ready high: 4D / B2 for one cycle.
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++)
      add(s[i], 1'b1, (i == 0), 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'(i + 1), 1'b0, 1'b0);
    add(s[7], 1'b1, 1'b0, 1'b1, 1'b0, 8'h4D, 8'hB2, 1'b1, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4D, 8'hB2, 1'b0, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4D, 8'hB2, 1'b0, 3'd0, 1'b0, 1'b0);
    // Ready low: 4D held, FF completes into a full slot and is dropped.
    for (int i = 0; i < 7; i++)
      add(s[i], 1'b1, 1'b0, 1'b0, 1'b0, 8'h4D, 8'hB2, 1'b0, 3'(i + 1), 1'b0, 1'b0);
    add(s[7], 1'b1, 1'b0, 1'b0, 1'b0, 8'h4D, 8'hB2, 1'b1, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++)
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h4D, 8'hB2, 1'b1, 3'(i + 1), 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h4D, 8'hB2, 1'b1, 3'd0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h4D, 8'hB2, 1'b1, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4D, 8'hB2, 1'b0, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4D, 8'hB2, 1'b0, 3'd0, 1'b0, 1'b0);

    foreach (tbl[k]) begin
      drive(tbl[k].din, tbl[k].vin, tbl[k].sof, tbl[k].rdy, tbl[k].rst);
      step();
      chk($sformatf("tbl%0d", k), tbl[k].el, tbl[k].em, tbl[k].ev, tbl[k].ec, tbl[k].eo, tbl[k].ef);
    end

    // Frame error: 3 bits, then SOF restarts the word; 8 ones total give FF.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step();
    chk("fe_rst", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0); step();
      chk("fe_pre", 8'h00, 8'h00, 1'b0, 3'(i + 1), 1'b0, 1'b0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); step();
    chk("fe_sof", 8'h00, 8'h00, 1'b0, 3'd1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); step();
      chk("fe_body", 8'h00, 8'h00, 1'b0, 3'(i + 2), 1'b0, 1'b0);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); step();
    chk("fe_done", 8'hFF, 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step();
    chk("fe_xfer", 8'hFF, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0);

    // Gapped input, ready only on each completion edge: words replace each other, no overflow.
    wl[0] = 8'h4D; wl[1] = 8'hA5; wl[2] = 8'h3C;
    wm[0] = 8'hB2; wm[1] = 8'hA5; wm[2] = 8'h3C;
    cur_l = 8'hFF; cur_m = 8'hFF; cur_v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        for (int g = 0; g < (i + k) % 4; g++) begin
          drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step();
          chk($sformatf("gap_w%0d_b%0d", k, i), cur_l, cur_m, cur_v, 3'(i), 1'b0, 1'b0);
        end
        s = wl[k];
        drive(s[i], 1'b1, 1'b0, (i == 7), 1'b0); step();
        if (i == 7) begin
          cur_l = wl[k]; cur_m = wm[k]; cur_v = 1'b1;
        end
        chk($sformatf("bit_w%0d_b%0d", k, i), cur_l, cur_m, cur_v, 3'((i + 1) % 8), 1'b0, 1'b0);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step();
    chk("gap_drain", 8'h3C, 8'h3C, 1'b0, 3'd0, 1'b0, 1'b0);

    // Reset with a held word and a 5-bit partial, then a clean 4D.
    s = 8'h4D;
    for (int i = 0; i < 8; i++) begin
      drive(s[i], 1'b1, 1'b0, 1'b0, 1'b0); step();
    end
    chk("rs_held", 8'h4D, 8'hB2, 1'b1, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
    end
    chk("rs_part", 8'h4D, 8'hB2, 1'b1, 3'd5, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); step();
    chk("rs_clr", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(s[i], 1'b1, 1'b0, 1'b1, 1'b0); step();
      chk("rs_body", 8'h00, 8'h00, 1'b0, 3'(i + 1), 1'b0, 1'b0);
    end
    drive(s[7], 1'b1, 1'b0, 1'b1, 1'b0); step();
    chk("rs_done", 8'h4D, 8'hB2, 1'b1, 3'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ser2par_param.md
SER2PAR_PARAM -- requirements
Module: ser2par_param

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 0: 0 places the first serial bit in dout[0]; 1 places it in dout[WIDTH-1].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  1  serial data bit; sampled only when valid_in=1.
REQ-006 valid_in  input  1  din qualifier; one bit accepted per cycle while high; no backpressure on this side.
REQ-007 sof_in  input  1  start-of-frame; with valid_in=1, the current din is bit 0 of a new word; ignored when valid_in=0.
REQ-008 dout  output  WIDTH  assembled parallel word, held stable while valid_out=1 and not accepted.
REQ-009 valid_out  output  1  dout holds an unconsumed word.
REQ-010 ready_out  input  1  downstream accept; transfer occurs on a cycle with valid_out=1 and ready_out=1.
REQ-011 bit_cnt  output  clog2(WIDTH)  number of bits of the current partial word accepted so far.
REQ-012 overflow  output  1  one-cycle pulse: completed word dropped because the output register was full.
REQ-013 frame_err  output  1  one-cycle pulse: sof_in discarded a non-empty partial word.

Function
REQ-014 The block SHALL shift each accepted bit into an internal WIDTH-bit assembly register at the position given by bit_cnt and MSB_FIRST, and increment bit_cnt.
REQ-015 On the edge that accepts bit WIDTH-1, the block SHALL wrap bit_cnt to 0 and mark the word complete.
REQ-016 On that same edge, a complete word SHALL load dout and set valid_out, so valid_out is high in the cycle after the last bit's valid_in cycle (latency 1).
REQ-017 Bits not yet written in the assembly register SHALL NOT appear in dout; dout equals exactly the WIDTH accepted bits.
REQ-018 valid_out SHALL clear on a transfer cycle unless a new word completes on that same edge, in which case dout SHALL load the new word and valid_out SHALL stay 1.
REQ-019 If a word completes while valid_out=1 and ready_out=0, the new word SHALL be dropped, dout and valid_out SHALL be unchanged, and overflow SHALL pulse high for one cycle.
REQ-020 valid_in=1 with sof_in=1 SHALL write din as bit 0 of a fresh word and set bit_cnt to 1.
REQ-021 In that case, if bit_cnt was nonzero, frame_err SHALL pulse high for one cycle and the partial bits SHALL be discarded.
REQ-022 sof_in does not affect dout or valid_out.
REQ-023 valid_in=0 SHALL hold bit_cnt and the assembly register unchanged.
REQ-024 ready_out with valid_out=0 SHALL have no effect.
REQ-025 dout and valid_out SHALL change only on completion or transfer.
REQ-026 No combinational path from ready_out to any output.

Reset
REQ-027 While rst=1 at a rising edge, the block SHALL clear dout, valid_out, bit_cnt, overflow, frame_err and the assembly register to 0; reset overrides all other inputs.
REQ-028 Reset mid-word SHALL discard the partial word with no frame_err pulse.
REQ-029 Reset with valid_out=1 SHALL drop the held word.
REQ-030 The first accepted bit after reset release SHALL be bit 0.

Structure
REQ-031 Shared package ser2par_pkg SHALL hold the bit-order constants LSB_FIRST=0 and MSB_FIRST=1 and the function computing the bit_cnt width from WIDTH.
REQ-032 Single module; no sub-module: the assembly register, counter and output register are small.

Verification
REQ-033 WIDTH=8, MSB_FIRST=0, ready_out=1, stream 1,0,1,1,0,0,1,0 on consecutive cycles -> dout=8'h4D, valid_out=1 for exactly one cycle, starting the cycle after the 8th bit.
REQ-034 Same stream with MSB_FIRST=1 -> dout=8'hB2.
REQ-035 ready_out=0, two full words 8'h4D then 8'hFF -> dout stays 8'h4D, overflow pulses once on the 16th-bit edge; then raising ready_out -> one transfer, then valid_out=0.
REQ-036 3 bits accepted, then valid_in=1 with sof_in=1 plus 7 more bits (all 1) -> frame_err pulses once, dout=8'hFF.
REQ-037 valid_in gaps of 0-3 cycles between bits, and ready_out asserted on the same edge a new word completes -> back-to-back words, valid_out held 1, no overflow.
REQ-038 rst=1 after 5 bits, then a full word 8'h4D -> all outputs 0 during reset, then dout=8'h4D with no frame_err.
